reg_op_sequencer: RTL and testbench

Control stage directly upstream of the 4-bit mode-select register (`Reg`). It accepts register operations over a valid/ready command interface and drives the register's one-hot mode selects `s1`..`s4` for a programmed number of clock cycles. It then samples the register outputs `q0`..`q3` once they have settled and returns the sampled value with a one-cycle `done` pulse.

---
 rtl/reg_op_sequencer.sv | 105 ++++++++++
 tb/tb_reg_op_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: command-driven sequencer for a 4-bit mode-select register.
// Holds one one-hot select for a programmed number of cycles, lets the
// register settle for one cycle, captures its outputs and pulses done.
module reg_op_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  input  logic             q0,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  output logic [3:0]       result,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       result_q, result_d;

  // Next-state logic. The select vector doubles as the latched op: it is
  // loaded at the handshake and cleared on the last RUN cycle, so the
  // outputs come straight from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        sel_d = 4'b0000;
        if (cmd_valid) begin
          if (cmd_cnt != '0) begin
            state_d = RUN;
            cnt_d   = cmd_cnt;
            sel_d   = 4'b0001 << cmd_op;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      RUN: begin
        // Count holds the cycles still to run including this one; the
        // select drops at the same edge that leaves RUN.
        if (abort || cnt_q == CNT_W'(1)) begin
          state_d = SETTLE;
          sel_d   = 4'b0000;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        sel_d    = 4'b0000;
        result_d = {q3, q2, q1, q0};
        state_d  = DONE;
      end
      DONE: begin
        sel_d   = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // State, count, select and result registers; reset drops selects at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 4'b0000;
      result_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  assign s1        = sel_q[0];
  assign s2        = sel_q[1];
  assign s3        = sel_q[2];
  assign s4        = sel_q[3];
  assign result    = result_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: behavioural mode-select register, table of
// commands, scoreboard of expected results, plus backpressure and reset runs.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_cnt = 4'd0;
  logic       abort = 1'b0;
  logic       s1, s2, s3, s4;
  logic       q0, q1, q2, q3;
  logic [3:0] result;
  logic       done, busy;

  logic [3:0] d_in = 4'b0000;
  logic [3:0] r = 4'b0000;
  logic [3:0] sel;
  logic [3:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  reg_op_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .abort(abort),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural register: load, shift right, shift left, clear (serial in 0).
  always @(posedge clk) begin
    if (s1)      r <= d_in;
    else if (s2) r <= {1'b0, r[3:1]};
    else if (s3) r <= {r[2:0], 1'b0};
    else if (s4) r <= 4'b0000;
  end
  assign {q3, q2, q1, q0} = r;
  assign sel = {s4, s3, s2, s1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pop the scoreboard on a done pulse and compare the captured result.
  task automatic sb_pop(input string nm);
    logic [3:0] e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: done with empty scoreboard, result %b", nm, result);
    end else begin
      e = sb_q.pop_front();
      if (result !== e) begin
        n_bad++;
        $display("FAIL %s: result %b expected %b", nm, result, e);
      end
    end
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready_wait"}, 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command and watch every cycle until well after it completes.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input int abort_at,
                         input logic [3:0] d, input logic [3:0] exp, input string nm);
    int eff, sel_n, other_n, done_n, done_at, bad;
    eff = (abort_at > 0 && abort_at < int'(cnt)) ? abort_at : int'(cnt);
    sel_n = 0; other_n = 0; done_n = 0; done_at = -1; bad = 0;
    wait_ready(nm);
    d_in = d; cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_cnt = 4'($urandom);
    for (int i = 1; i <= eff + 6; i++) begin
      @(negedge clk);
      if (sel[op]) sel_n++;
      if ((sel & ~(4'b0001 << op)) != 4'b0000) other_n++;
      if (busy !== (i <= eff + 2)) bad++;
      if (cmd_ready !== !busy) bad++;
      if (done) begin
        done_n++;
        done_at = i;
        sb_pop({nm, " result"});
      end
      abort = (i == abort_at);
    end
    abort = 1'b0;
    chk({nm, " sel_cycles"}, 32'(sel_n), 32'(eff));
    chk({nm, " other_sel"}, 32'(other_n), 32'd0);
    chk({nm, " done_count"}, 32'(done_n), 32'd1);
    chk({nm, " done_cycle"}, 32'(done_at), 32'(eff + 2));
    chk({nm, " busy_ready"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    int         abort_at;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int bad, rdy_bad, done_n;
    logic [3:0] exp_sel;

    tbl[0] = '{2'd0, 4'd1,  0, 4'b1010, 4'b1010};  // load
    tbl[1] = '{2'd0, 4'd1,  0, 4'b1000, 4'b1000};  // load 1000
    tbl[2] = '{2'd1, 4'd3,  0, 4'b1111, 4'b0001};  // shift right x3
    tbl[3] = '{2'd3, 4'd0,  0, 4'b1111, 4'b0001};  // clear with cnt 0: no pulse
    tbl[4] = '{2'd3, 4'd1,  0, 4'b1111, 4'b0000};  // clear
    tbl[5] = '{2'd0, 4'd2,  0, 4'b0011, 4'b0011};  // load twice
    tbl[6] = '{2'd2, 4'd10, 3, 4'b1111, 4'b1000};  // shift left, abort in 3rd cycle
    tbl[7] = '{2'd0, 4'd15, 0, 4'b0101, 4'b0101};  // maximum count
    tbl[8] = '{2'd2, 4'd1,  0, 4'b1111, 4'b1010};  // shift left once
    tbl[9] = '{2'd1, 4'd2,  0, 4'b1111, 4'b0010};  // shift right x2

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < 10; k++)
      run_cmd(tbl[k].op, tbl[k].cnt, tbl[k].abort_at, tbl[k].d, tbl[k].exp,
              $sformatf("vec%0d", k));

    // Backpressure: valid held with changing fields during a cnt=5 load;
    // the fields present in the first IDLE cycle form the second command.
    wait_ready("bp");
    d_in = 4'b1100; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_cnt = 4'd5;
    sb_q.push_back(4'b1100);
    @(posedge clk);
    #1;
    bad = 0; rdy_bad = 0; done_n = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_sel = (i <= 5) ? 4'b0001 : (i == 9 || i == 10) ? 4'b0010 : 4'b0000;
      if (sel !== exp_sel) bad++;
      if (cmd_ready !== (i == 8 || i >= 13)) rdy_bad++;
      if (done) begin
        done_n++;
        if (i != 7 && i != 12) bad++;
        sb_pop("bp result");
      end
      if (i < 8) begin
        cmd_op = 2'(i % 3 + 1);
        cmd_cnt = 4'($urandom_range(1, 15));
      end else if (i == 8) begin
        cmd_op = 2'd1; cmd_cnt = 4'd2;
        sb_q.push_back(4'b0011);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("bp sel_done", 32'(bad), 32'd0);
    chk("bp cmd_ready", 32'(rdy_bad), 32'd0);
    chk("bp done_count", 32'(done_n), 32'd2);

    // Asynchronous reset in the middle of RUN
    wait_ready("mid_rst");
    d_in = 4'b1111; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_cnt = 4'd8;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst s2 before", 32'(s2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst sel", 32'(sel), 32'd0);
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("mid_rst no_done", 32'(done_n), 32'd0);
    run_cmd(2'd0, 4'd1, 0, 4'b0110, 4'b0110, "recover");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
